// File: rtl/demux16_reg.sv
`default_nettype none
// ============================================================================
// Module   : demux16_reg
// Purpose  : Registered 1-to-(2**SEL_W) demultiplexer. Routes the data bit f
//            to output line y[s]. All other lines are driven 0. The demux is
//            built as a tree of 1:2 stages. s[MSB] splits at the root and
//            s[0] splits at the leaves. The tree result is captured in an
//            output register together with a one-hot integrity flag.
// Ports    : clk        - system clock, rising edge
//            rst_n      - asynchronous active-low reset (clears y/onehot_err)
//            en         - load enable for the output register
//            f          - data bit to route
//            s          - line select, s[SEL_W-1] = root stage
//            y          - registered demux output, y[i] <-> s == i
//            onehot_err - registered flag, 1 when captured y has >1 bit set
// Revision : 1.0 - initial release
// ============================================================================
module demux16_reg #(
  parameter int SEL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  f,
  input  logic [SEL_W-1:0]      s,
  output logic [(2**SEL_W)-1:0] y,
  output logic                  onehot_err
);

  localparam int N = 2**SEL_W;

  // One 1:2 demux stage: {hi, lo}
  function automatic logic [1:0] demux2(input logic in_bit, input logic sel);
    demux2 = {in_bit & sel, in_bit & ~sel};
  endfunction

  // Tree levels. Level l holds 2**l live nodes in bits [2**l-1:0]; the
  // remaining upper bits are held at 0. Node k of level l feeds nodes 2k (lo)
  // and 2k+1 (hi) of level l+1. The leaf index therefore equals s, MSB first.
  logic [N-1:0] lvl_w [SEL_W+1];
  logic [N-1:0] y_d;
  logic         err_d;
  logic [N-1:0] y_q;
  logic         err_q;

  always_comb begin
    for (int l = 0; l <= SEL_W; l++) begin
      lvl_w[l] = '0;
    end
    lvl_w[0][0] = f;
    for (int l = 0; l < SEL_W; l++) begin
      for (int k = 0; k < N / 2; k++) begin
        if (k < (1 << l)) begin
          {lvl_w[l+1][2*k+1], lvl_w[l+1][2*k]} = demux2(lvl_w[l][k], s[SEL_W-1-l]);
        end
      end
    end
  end

  assign y_d = lvl_w[SEL_W];

  // Clearing the lowest set bit leaves a non-zero value exactly when two or
  // more bits were set.
  assign err_d = ((y_d & (y_d - {{(N-1){1'b0}}, 1'b1})) != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      err_q <= 1'b0;
    end else if (en) begin
      y_q   <= y_d;
      err_q <= err_d;
    end
  end

  assign y          = y_q;
  assign onehot_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_demux16_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux16_reg
// Purpose  : Self-checking bench for demux16_reg. A driver issues directed
//            vectors and pushes the hand-computed response, tagged with the
//            cycle it is due, into a queue. A monitor on the falling edge
//            pops and compares the register outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux16_reg;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        f;
  logic [3:0]  s;
  logic [15:0] y;
  logic        onehot_err;

  demux16_reg #(.SEL_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .f          (f),
    .s          (s),
    .y          (y),
    .onehot_err (onehot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] y;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every entry whose due cycle is the one just clocked.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("sb_y", y, e.y);
      chk("sb_onehot_err", {15'd0, onehot_err}, 16'h0000);
    end
  end

  // Drive one vector just after a rising edge; it is sampled on the next one.
  task automatic step(input logic en_v, input logic f_v, input logic [3:0] s_v,
                      input logic [15:0] exp_y);
    exp_t e;
    @(posedge clk);
    #1;
    en = en_v;
    f  = f_v;
    s  = s_v;
    e.due = cyc + 1;
    e.y   = exp_y;
    q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk);
      n = n + 1;
    end
    @(negedge clk);
    #2;
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain_timeout: pending %0d expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    // Reset held with live inputs: outputs must stay clear across edges.
    rst_n = 1'b0;
    en    = 1'b1;
    f     = 1'b1;
    s     = 4'h5;
    #1;
    chk("reset_y_t0", y, 16'h0000);
    chk("reset_err_t0", {15'd0, onehot_err}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("reset_y_held", y, 16'h0000);
      chk("reset_err_held", {15'd0, onehot_err}, 16'h0000);
    end
    // Release between edges; the next rising edge loads s=5.
    begin
      exp_t e;
      rst_n = 1'b1;
      e.due = cyc + 1;
      e.y   = 16'h0020;
      q.push_back(e);
    end
    drain();

    // Exhaustive route with f=1.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 4'(i), 16'h0001 << i);
    end
    // Zero data.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 4'(i), 16'h0000);
    end

    // Enable hold.
    step(1'b1, 1'b1, 4'hA, 16'h0400);
    step(1'b0, 1'b0, 4'h3, 16'h0400);
    step(1'b0, 1'b0, 4'h3, 16'h0400);
    step(1'b0, 1'b0, 4'h3, 16'h0400);
    step(1'b1, 1'b0, 4'h3, 16'h0000);

    // Async reset mid-stream.
    step(1'b1, 1'b1, 4'hF, 16'h8000);
    step(1'b0, 1'b1, 4'hF, 16'h8000);
    drain();
    chk("pre_reset_y", y, 16'h8000);
    en    = 1'b1;
    f     = 1'b1;
    s     = 4'h7;
    rst_n = 1'b0;
    #1;
    chk("async_reset_y", y, 16'h0000);
    chk("async_reset_err", {15'd0, onehot_err}, 16'h0000);
    rst_n = 1'b1;
    #1;
    chk("after_release_y", y, 16'h0000);
    begin
      exp_t e;
      e.due = cyc + 1;
      e.y   = 16'h0080;
      q.push_back(e);
    end

    // Back-to-back selects.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step(1'b1, 1'b1, 4'h0, 16'h0001);
      else            step(1'b1, 1'b1, 4'hF, 16'h8000);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
